saph_blend: RTL
===============

# saph_blend

Read-modify-write blend stage directly upstream of `saph_colmath`. It accepts pixel blend requests (framebuffer address, source colour, coefficient, mode) and issues a framebuffer read. It presents source and destination to an internal `saph_colmath` instance and writes the result back. Throughput is one pixel per cycle, with read-after-write hazards on the same address handled in-block.

## Interface
- `ADDR_W`, 16: framebuffer word address width.
- `RD_LAT`, 2: fixed framebuffer read latency in cycles, legal range 1..4.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted when `req_valid & req_ready`.
- `req_addr`  in  ADDR_W: destination pixel address.
- `req_col`  in  32: source `color`, ARGB8888; drives colmath `a`.
- `req_coef`  in  8: coefficient; drives colmath `c`.
- `req_mode`  in  `SAPH_COLMATH_MODE_W`: colmath mode.
- `mem_rd_en`  out  1: read strobe.
- `mem_rd_addr`  out  ADDR_W: read address.
- `mem_rd_data`  in  32: read data, valid exactly `RD_LAT` cycles after `mem_rd_en`.
- `mem_wr_en`  out  1: write strobe; the memory always accepts.
- `mem_wr_addr`  out  ADDR_W: write address.
- `mem_wr_data`  out  32: blended colour.
- `busy`  out  1: any pipeline stage valid.
- `pix_count`  out  32: number of completed writes; wraps at 2^32.

## Operation
- **Accept:**
  - `mem_rd_en = req_valid & req_ready` (combinational).
  - `mem_rd_addr = req_addr`.
  - Accept cycle T places {addr, col, coef, mode} into stage 1, which valid-shifts to stage `RD_LAT` at T+`RD_LAT`.
- **Compute (cycle T+`RD_LAT`):** colmath is driven with `a`=col, `b`=dest, `c`=coef, `mode`=mode. Dest is `mem_rd_data`, or the forwarded value (see Configuration).
- **Write stage:** q, addr and valid are registered. `mem_wr_en`/`mem_wr_addr`/`mem_wr_data` are driven from these registers at T+`RD_LAT`+1. `pix_count` increments on every `mem_wr_en`.
- **Memory model:** a read and a write to the same address in the same cycle returns the pre-write data.
- **Hazard (forwarding compiled out):** `req_ready`=0 while `req_addr` equals the addr of any valid entry in stages 1..`RD_LAT` or in the write stage. Consequence: the next same-address request is accepted no earlier than T+`RD_LAT`+2.
- **No hazard:** `req_ready`=1.
  - `req_ready` must not depend on `req_valid`.
  - No other backpressure exists.
- **Reset (asserted, any time):**
  - All valids clear; in-flight writes are dropped.
  - All outputs go to 0, including `req_ready`, `busy` and `pix_count`.
  - `req_ready` rises in the first cycle after deassertion.

## Timing
- Latency: accept at T → `mem_wr_en` at T+`RD_LAT`+1.
- Sustained rate is 1 pixel/cycle with distinct addresses. `busy` falls the cycle after the last `mem_wr_en`.
- colmath is combinational. The critical path runs `mem_rd_data` → forward mux → colmath → write register.

## Configuration
- `SAPH_BLEND_FWD_EN` defined:
  - A write history holds the last `RD_LAT`+1 writes (addr, data), including the current write-stage register.
  - At compute, dest is the data of the newest valid history entry whose addr matches; if none matches, dest is `mem_rd_data`.
  - The hazard stall is removed; `req_ready`=1 except during reset.
- `SAPH_BLEND_FWD_EN` undefined: no history; the stall rule above applies.
- Write data is identical in both builds for any request sequence.

## Structure
- `color` and the `SAPH_COLMATH_*` mode constants/width stay in `saph_defines.svh`. Add `saph_blend_req_t` (addr, col, coef, mode) there; `ADDR_W` is a parameter, so the addr field uses the 16-bit default.
- `saph_colmath` is instantiated inside.
- Sub-module `saph_blend_fwd`: the history buffer plus match/priority mux. It is only instantiated under `SAPH_BLEND_FWD_EN`.

## Test plan
- **Single pixel:** mem[0x10]=ff00ff00; request addr 0x10, col 7fff0000, coef 7f, `SAPH_COLMATH_INTERP` → `mem_wr_en` at T+3 (`RD_LAT`=2). Addr 0x10; data equals a reference `saph_colmath` output for those operands. `pix_count`=1.
- **Streaming:** 64 back-to-back requests to distinct addresses → `req_ready` stays 1; 64 writes on consecutive cycles, each matching the model; `busy` falls the cycle after the last write.
- **Same-address pair, forwarding off:** two requests to 0x20 on consecutive cycles → second accepted exactly at T+4. Its dest is the first result.
- **Same-address pair, `SAPH_BLEND_FWD_EN`:** same stimulus → no stall; second write at T+4. Final mem[0x20] matches the no-forward build.
- **Reset mid-stream:** assert `rst` low with 3 requests in flight → no further `mem_wr_en`; all outputs 0. After release, `req_ready`=1 next cycle and a new request completes normally.
- **Randomized:** random addrs in 0..3 with random valid gaps, run with `RD_LAT`=1 and 4 → final memory equals a sequential golden model.

Source files
------------

// File: rtl/saph_blend_pkg.sv
// Shared colour, colmath mode and request types for the saph blend stage.
package saph_blend_pkg;

   localparam int unsigned SAPH_COLMATH_MODE_W = 2;

   localparam logic [SAPH_COLMATH_MODE_W-1:0] SAPH_COLMATH_INTERP = 2'd0;
   localparam logic [SAPH_COLMATH_MODE_W-1:0] SAPH_COLMATH_ADD    = 2'd1;
   localparam logic [SAPH_COLMATH_MODE_W-1:0] SAPH_COLMATH_SUB    = 2'd2;
   localparam logic [SAPH_COLMATH_MODE_W-1:0] SAPH_COLMATH_MUL    = 2'd3;

   // ARGB8888
   typedef logic [31:0] color;

   typedef struct packed {
      color                           col;
      logic [7:0]                     coef;
      logic [SAPH_COLMATH_MODE_W-1:0] mode;
   } saph_blend_op_t;

   // Address field fixed at the 16-bit default width.
   typedef struct packed {
      logic [15:0]    addr;
      saph_blend_op_t op;
   } saph_blend_req_t;

endpackage

// File: rtl/saph_blend_fwd.sv
// Write history for saph_blend forwarding (built only with SAPH_BLEND_FWD_EN).
module saph_blend_fwd
   import saph_blend_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  color              wr_data_i,
   input  logic [ADDR_W-1:0] lk_addr_i,
   input  color              rd_data_i,
   output color              dest_o
);

   // Entry i holds the write-stage contents from i+1 cycles ago.
   logic [DEPTH-1:0]  vld_q;
   logic [ADDR_W-1:0] addr_q [DEPTH];
   color              data_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0]  <= wr_en_i;
         addr_q[0] <= wr_addr_i;
         data_q[0] <= wr_data_i;
         for (int i = 1; i < int'(DEPTH); i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
            data_q[i] <= data_q[i-1];
         end
      end
   end

   // Oldest first so the newest match overrides.
   always_comb begin
      dest_o = rd_data_i;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (vld_q[i] && (addr_q[i] == lk_addr_i)) dest_o = data_q[i];
      end
      if (wr_en_i && (wr_addr_i == lk_addr_i)) dest_o = wr_data_i;
   end

endmodule

// File: rtl/saph_colmath.sv
// Combinational per-channel ARGB8888 colour math: interpolate, saturating add/sub, multiply.
module saph_colmath
   import saph_blend_pkg::*;
(
   input  color                           a_i,
   input  color                           b_i,
   input  logic [7:0]                     c_i,
   input  logic [SAPH_COLMATH_MODE_W-1:0] mode_i,
   output color                           q_o
);

   function automatic logic [7:0] chan_op(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c,
                                          input logic [SAPH_COLMATH_MODE_W-1:0] mode);
      logic [15:0] mix;
      logic [8:0]  sum;
      mix     = '0;
      sum     = '0;
      chan_op = '0;
      unique case (mode)
         SAPH_COLMATH_INTERP: begin
            // +255 bias makes c=ff return a exactly and c=00 return b exactly
            mix     = 16'(a) * 16'(c) + 16'(b) * 16'(8'd255 - c) + 16'd255;
            chan_op = 8'(mix >> 8);
         end
         SAPH_COLMATH_ADD: begin
            sum     = 9'(a) + 9'(b);
            chan_op = sum[8] ? 8'hff : sum[7:0];
         end
         SAPH_COLMATH_SUB: chan_op = (b >= a) ? (b - a) : 8'h00;
         SAPH_COLMATH_MUL: begin
            mix     = 16'(a) * 16'(b) + 16'd255;
            chan_op = 8'(mix >> 8);
         end
         default: chan_op = '0;
      endcase
   endfunction

   always_comb begin
      q_o = '0;
      for (int ch = 0; ch < 4; ch++) begin
         q_o[ch*8 +: 8] = chan_op(a_i[ch*8 +: 8], b_i[ch*8 +: 8], c_i, mode_i);
      end
   end

endmodule

// File: rtl/saph_blend.sv
// Read-modify-write blend stage feeding saph_colmath; one pixel per cycle.
// Define SAPH_BLEND_FWD_EN to replace the same-address stall with write forwarding.
module saph_blend
   import saph_blend_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [ADDR_W-1:0]              req_addr,
   input  color                           req_col,
   input  logic [7:0]                     req_coef,
   input  logic [SAPH_COLMATH_MODE_W-1:0] req_mode,
   output logic                           mem_rd_en,
   output logic [ADDR_W-1:0]              mem_rd_addr,
   input  color                           mem_rd_data,
   output logic                           mem_wr_en,
   output logic [ADDR_W-1:0]              mem_wr_addr,
   output color                           mem_wr_data,
   output logic                           busy,
   output logic [31:0]                    pix_count
);

   localparam int unsigned LAST = RD_LAT - 1;

   logic [RD_LAT-1:0] st_vld_q;
   logic [ADDR_W-1:0] st_addr_q [RD_LAT];
   saph_blend_op_t    st_op_q   [RD_LAT];
   logic              wr_vld_q;
   logic [ADDR_W-1:0] wr_addr_q;
   color              wr_data_q;
   logic [31:0]       cnt_q;
   logic              run_q;
   color              dest;
   color              blend;

   assign mem_rd_en   = req_valid & req_ready;
   // Held at zero while in reset so every output is quiet.
   assign mem_rd_addr = run_q ? req_addr : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q     <= 1'b0;
         st_vld_q  <= '0;
         wr_vld_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) begin
            st_addr_q[i] <= '0;
            st_op_q[i]   <= '0;
         end
      end else begin
         run_q        <= 1'b1;
         st_vld_q[0]  <= mem_rd_en;
         st_addr_q[0] <= req_addr;
         st_op_q[0]   <= '{col: req_col, coef: req_coef, mode: req_mode};
         for (int i = 1; i < int'(RD_LAT); i++) begin
            st_vld_q[i]  <= st_vld_q[i-1];
            st_addr_q[i] <= st_addr_q[i-1];
            st_op_q[i]   <= st_op_q[i-1];
         end
         wr_vld_q  <= st_vld_q[LAST];
         wr_addr_q <= st_addr_q[LAST];
         wr_data_q <= blend;
         cnt_q     <= cnt_q + 32'(wr_vld_q);
      end
   end

`ifdef SAPH_BLEND_FWD_EN
   saph_blend_fwd #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RD_LAT)
   ) u_fwd (
      .clk_i     (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_vld_q),
      .wr_addr_i (wr_addr_q),
      .wr_data_i (wr_data_q),
      .lk_addr_i (st_addr_q[LAST]),
      .rd_data_i (mem_rd_data),
      .dest_o    (dest)
   );

   assign req_ready = run_q;
`else
   logic hazard;

   // Any in-flight write to this address would be missed by the new read.
   always_comb begin
      hazard = wr_vld_q && (wr_addr_q == req_addr);
      for (int i = 0; i < int'(RD_LAT); i++) begin
         if (st_vld_q[i] && (st_addr_q[i] == req_addr)) hazard = 1'b1;
      end
   end

   assign dest      = mem_rd_data;
   assign req_ready = run_q & ~hazard;
`endif

   saph_colmath u_colmath (
      .a_i    (st_op_q[LAST].col),
      .b_i    (dest),
      .c_i    (st_op_q[LAST].coef),
      .mode_i (st_op_q[LAST].mode),
      .q_o    (blend)
   );

   assign mem_wr_en   = wr_vld_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign busy        = (|st_vld_q) | wr_vld_q;
   assign pix_count   = cnt_q;

endmodule
